icache_fill_ctrl: RTL and testbench

Memory-side responder for instruction-cache line fills. It accepts 15-bit line requests from the icache miss path with a `req_vld`/`req_rd` handshake and fetches the 32-byte line from the memory bus as a burst of beats. It assembles the line and returns it to the icache on the `mem_data`/`mem_vld`/`mem_addr` fill port. It holds one active fill plus one pending request, so both halves of a line-spanning fetch can be queued back to back.

---
 rtl/icache_fill_ctrl.sv | 141 ++++++++++++++
 tb/tb_icache_fill_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache line fill responder: queues up to two line requests,
// fetches each line as a bus burst and returns the assembled 256-bit line.
module icache_fill_ctrl #(
  parameter int BEAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  input  logic [14:0]       req_addr,
  output logic              req_rd,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [14:0]       bus_addr,
  input  logic              bus_rd_vld,
  input  logic [BEAT_W-1:0] bus_rd_data,
  output logic              mem_vld,
  output logic [255:0]      mem_data,
  output logic [14:0]       mem_addr
);

  localparam int NB = 256 / BEAT_W;
  localparam int CW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_e;

  state_e          state_q, state_d;
  logic            act_v_q, act_v_d;
  logic            pend_v_q, pend_v_d;
  logic [9:0]      act_line_q, act_line_d;
  logic [9:0]      pend_line_q, pend_line_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BEAT_W-1:0]            buf_q [NB-1];
  logic [(NB-1)*BEAT_W-1:0]     line_buf;

  logic [9:0] req_line;
  logic       dup;
  logic       accept;
  logic       beat;
  logic       last;
  logic       unused_ok;

  assign req_line  = req_addr[14:5];
  assign unused_ok = ^req_addr[4:0];
  assign dup       = (act_v_q && (req_line == act_line_q)) ||
                     (pend_v_q && (req_line == pend_line_q));
  assign req_rd    = req_vld & ~rst & (~pend_v_q | dup);
  assign accept    = req_rd & ~dup;
  assign beat      = (state_q == XFER) && bus_rd_vld;
  assign last      = beat && (cnt_q == CW'(NB - 1));

  always_comb begin
    state_d     = state_q;
    act_v_d     = act_v_q;
    act_line_d  = act_line_q;
    pend_v_d    = pend_v_q;
    pend_line_d = pend_line_q;
    cnt_d       = cnt_q;
    bus_req     = 1'b0;
    mem_vld     = 1'b0;

    if (last) begin
      if (pend_v_q) begin
        act_line_d = pend_line_q;
        pend_v_d   = 1'b0;
      end else begin
        act_v_d = 1'b0;
      end
    end

    // A request taken on the last beat with pending empty goes straight to active.
    if (accept) begin
      if (!act_v_q || last) begin
        act_v_d    = 1'b1;
        act_line_d = req_line;
      end else begin
        pend_v_d    = 1'b1;
        pend_line_d = req_line;
      end
    end

    case (state_q)
      IDLE: begin
        if (act_v_d) state_d = ARB;
      end
      ARB: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          state_d = XFER;
          cnt_d   = '0;
        end
      end
      XFER: begin
        bus_req = 1'b1;
        if (beat) cnt_d = cnt_q + 1'b1;
        if (last) begin
          mem_vld = 1'b1;
          state_d = act_v_d ? ARB : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      bus_req = 1'b0;
      mem_vld = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      act_v_q     <= 1'b0;
      pend_v_q    <= 1'b0;
      act_line_q  <= '0;
      pend_line_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      act_v_q     <= act_v_d;
      pend_v_q    <= pend_v_d;
      act_line_q  <= act_line_d;
      pend_line_q <= pend_line_d;
      cnt_q       <= cnt_d;
    end
  end

  // The final beat bypasses the buffer, so only NB-1 beats are stored.
  generate
    for (genvar gi = 0; gi < NB - 1; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (beat && (cnt_q == CW'(gi))) buf_q[gi] <= bus_rd_data;
      end
      assign line_buf[gi*BEAT_W +: BEAT_W] = buf_q[gi];
    end
  endgenerate

  assign mem_data = {bus_rd_data, line_buf};
  assign bus_addr = rst ? 15'd0 : {act_line_q, 5'b0};
  assign mem_addr = rst ? 15'd0 : {act_line_q, 5'b0};

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: 32-bit and 64-bit beat instances.
module tb_icache_fill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_vld, bus_gnt, bus_rd_vld;
  logic [14:0]  req_addr;
  logic [31:0]  bus_rd_data;
  logic         req_rd, bus_req, mem_vld;
  logic [14:0]  bus_addr, mem_addr;
  logic [255:0] mem_data;

  logic         req_vld_w, bus_gnt_w, bus_rd_vld_w;
  logic [14:0]  req_addr_w;
  logic [63:0]  bus_rd_data_w;
  logic         req_rd_w, bus_req_w, mem_vld_w;
  logic [14:0]  bus_addr_w, mem_addr_w;
  logic [255:0] mem_data_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  icache_fill_ctrl #(.BEAT_W(32)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr), .req_rd(req_rd),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr),
    .bus_rd_vld(bus_rd_vld), .bus_rd_data(bus_rd_data),
    .mem_vld(mem_vld), .mem_data(mem_data), .mem_addr(mem_addr)
  );

  icache_fill_ctrl #(.BEAT_W(64)) dut_w (
    .clk(clk), .rst(rst), .req_vld(req_vld_w), .req_addr(req_addr_w), .req_rd(req_rd_w),
    .bus_req(bus_req_w), .bus_gnt(bus_gnt_w), .bus_addr(bus_addr_w),
    .bus_rd_vld(bus_rd_vld_w), .bus_rd_data(bus_rd_data_w),
    .mem_vld(mem_vld_w), .mem_data(mem_data_w), .mem_addr(mem_addr_w)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [255:0] exp32(input logic [31:0] base);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = base + k;
    return v;
  endfunction

  // Waits (bounded) for bus_req, grants, then supplies 8 back-to-back beats base+k.
  task automatic burst32(input int gnt_delay, input logic [31:0] base,
                         output logic to, output logic [14:0] ga, output int pulses,
                         output logic [14:0] ma, output logic [255:0] md,
                         output logic [7:0] rd_hist);
    int w;
    to = 1'b0; pulses = 0; ma = '0; md = '0; rd_hist = '0;
    #1;
    w = 0;
    while (!bus_req && w < 20) begin
      @(posedge clk); #3; w++;
    end
    if (!bus_req) to = 1'b1;
    for (int d = 0; d < gnt_delay; d++) begin
      @(posedge clk); #3;
    end
    bus_gnt = 1'b1;
    ga = bus_addr;
    step();
    bus_gnt = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus_rd_vld  = 1'b1;
      bus_rd_data = base + k;
      #1;
      rd_hist[k] = req_rd;
      if (mem_vld) begin
        pulses++;
        ma = mem_addr;
        md = mem_data;
      end
      step();
    end
    bus_rd_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_vld = 1'b1; req_addr = 15'h1234; bus_gnt = 1'b0;
    bus_rd_vld = 1'b0; bus_rd_data = '0;
    req_vld_w = 1'b0; req_addr_w = '0; bus_gnt_w = 1'b0; bus_rd_vld_w = 1'b0; bus_rd_data_w = '0;
    step(); step(); step();
    #1;
    n_checks++; if (req_rd !== 1'b0) begin n_fail++; $display("FAIL reset_req_rd got %b want 0", req_rd); end
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req got %b want 0", bus_req); end
    n_checks++; if (mem_vld !== 1'b0) begin n_fail++; $display("FAIL reset_mem_vld got %b want 0", mem_vld); end
    n_checks++; if (bus_addr !== 15'h0) begin n_fail++; $display("FAIL reset_bus_addr got %h want 0", bus_addr); end
    n_checks++; if (mem_addr !== 15'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    req_vld = 1'b0;
    step();
    rst = 1'b0;
    step();
    #1;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle bus_req got %b want 0", bus_req); end
    $display("reset: done");
    step();
  endtask

  task automatic test_single_fill();
    int pulses = 0;
    req_vld = 1'b1; req_addr = 15'h1234;
    #1;
    n_checks++; if (req_rd !== 1'b1) begin n_fail++; $display("FAIL single_req_rd got %b want 1", req_rd); end
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL single_bus_req_T got %b want 0", bus_req); end
    step();
    req_vld = 1'b0;
    #1;
    n_checks++; if (req_rd !== 1'b0) begin n_fail++; $display("FAIL single_req_rd_T1 got %b want 0", req_rd); end
    n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL single_bus_req_T1 got %b want 1", bus_req); end
    n_checks++; if (bus_addr !== 15'h1220) begin n_fail++; $display("FAIL single_bus_addr got %h want 1220", bus_addr); end
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus_rd_vld = 1'b1; bus_rd_data = k;
      #1;
      if (mem_vld) pulses++;
      n_checks++; if (mem_vld !== (k == 7)) begin n_fail++; $display("FAIL single_mem_vld beat %0d got %b want %b", k, mem_vld, (k == 7)); end
      if (k == 7) begin
        n_checks++; if (mem_addr !== 15'h1220) begin n_fail++; $display("FAIL single_mem_addr got %h want 1220", mem_addr); end
        n_checks++; if (mem_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL single_data_lo got %h want 0", mem_data[31:0]); end
        n_checks++; if (mem_data[255:224] !== 32'h7) begin n_fail++; $display("FAIL single_data_hi got %h want 7", mem_data[255:224]); end
        n_checks++; if (mem_data !== exp32(32'h0)) begin n_fail++; $display("FAIL single_data got %h want %h", mem_data, exp32(32'h0)); end
      end
      step();
    end
    bus_rd_vld = 1'b0;
    #1;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL single_bus_req_after got %b want 0", bus_req); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL single_pulses got %0d want 1", pulses); end
    $display("single_fill: addr=1220 pulses=%0d", pulses);
    step();
  endtask

  task automatic test_split_pair();
    logic to; logic [14:0] ga, ma; int pulses; logic [255:0] md; logic [7:0] rh;
    req_vld = 1'b1; req_addr = 15'h00E0;
    #1;
    n_checks++; if (req_rd !== 1'b1) begin n_fail++; $display("FAIL split_req1_rd got %b want 1", req_rd); end
    step();
    req_addr = 15'h0100;
    #1;
    n_checks++; if (req_rd !== 1'b1) begin n_fail++; $display("FAIL split_req2_rd got %b want 1", req_rd); end
    step();
    req_vld = 1'b0;
    burst32(0, 32'h100, to, ga, pulses, ma, md, rh);
    n_checks++; if (to || ga !== 15'h00E0) begin n_fail++; $display("FAIL split_burst1_addr got %h to=%b want 00e0", ga, to); end
    n_checks++; if (pulses != 1 || ma !== 15'h00E0 || md !== exp32(32'h100)) begin n_fail++; $display("FAIL split_fill1 got pulses=%0d addr=%h want 1 00e0", pulses, ma); end
    #1;
    n_checks++; if (bus_req !== 1'b1 || bus_addr !== 15'h0100) begin n_fail++; $display("FAIL split_no_bubble got bus_req=%b addr=%h want 1 0100", bus_req, bus_addr); end
    burst32(0, 32'h200, to, ga, pulses, ma, md, rh);
    n_checks++; if (to || ga !== 15'h0100) begin n_fail++; $display("FAIL split_burst2_addr got %h to=%b want 0100", ga, to); end
    n_checks++; if (pulses != 1 || ma !== 15'h0100 || md !== exp32(32'h200)) begin n_fail++; $display("FAIL split_fill2 got pulses=%0d addr=%h want 1 0100", pulses, ma); end
    #1;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL split_idle got %b want 0", bus_req); end
    $display("split_pair: fills 00e0 then 0100");
    step();
  endtask

  task automatic test_duplicate();
    logic to; logic [14:0] ga, ma; int pulses; logic [255:0] md; logic [7:0] rh;
    logic seen;
    req_vld = 1'b1; req_addr = 15'h0044;
    #1;
    n_checks++; if (req_rd !== 1'b1) begin n_fail++; $display("FAIL dup_first_rd got %b want 1", req_rd); end
    step();
    req_addr = 15'h0040;
    #1;
    n_checks++; if (req_rd !== 1'b1) begin n_fail++; $display("FAIL dup_rd got %b want 1", req_rd); end
    step();
    req_vld = 1'b0;
    burst32(1, 32'h300, to, ga, pulses, ma, md, rh);
    n_checks++; if (to || pulses != 1 || ma !== 15'h0040) begin n_fail++; $display("FAIL dup_fill got pulses=%0d addr=%h want 1 0040", pulses, ma); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; if (bus_req) seen = 1'b1;
      step();
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL dup_second_fetch got bus_req=%b want 0", seen); end
    $display("dup: single fill for line 0040");
  endtask

  task automatic test_backpressure();
    logic to; logic [14:0] ga, ma; int pulses; logic [255:0] md; logic [7:0] rh;
    req_vld = 1'b1; req_addr = 15'h0000;
    #1;
    n_checks++; if (req_rd !== 1'b1) begin n_fail++; $display("FAIL bp_req0_rd got %b want 1", req_rd); end
    step();
    req_addr = 15'h0020;
    #1;
    n_checks++; if (req_rd !== 1'b1) begin n_fail++; $display("FAIL bp_req1_rd got %b want 1", req_rd); end
    step();
    req_addr = 15'h0060;
    #1;
    n_checks++; if (req_rd !== 1'b0) begin n_fail++; $display("FAIL bp_full_rd got %b want 0", req_rd); end
    burst32(0, 32'h400, to, ga, pulses, ma, md, rh);
    n_checks++; if (rh !== 8'h00) begin n_fail++; $display("FAIL bp_rd_during_burst got %b want 00000000", rh); end
    n_checks++; if (to || pulses != 1 || ma !== 15'h0000) begin n_fail++; $display("FAIL bp_fill1 got pulses=%0d addr=%h want 1 0000", pulses, ma); end
    #1;
    n_checks++; if (req_rd !== 1'b1) begin n_fail++; $display("FAIL bp_accept_after got %b want 1", req_rd); end
    n_checks++; if (bus_addr !== 15'h0020) begin n_fail++; $display("FAIL bp_next_addr got %h want 0020", bus_addr); end
    step();
    req_vld = 1'b0;
    burst32(0, 32'h500, to, ga, pulses, ma, md, rh);
    n_checks++; if (to || pulses != 1 || ma !== 15'h0020) begin n_fail++; $display("FAIL bp_fill2 got pulses=%0d addr=%h want 1 0020", pulses, ma); end
    burst32(0, 32'h600, to, ga, pulses, ma, md, rh);
    n_checks++; if (to || pulses != 1 || ma !== 15'h0060 || md !== exp32(32'h600)) begin n_fail++; $display("FAIL bp_fill3 got pulses=%0d addr=%h want 1 0060", pulses, ma); end
    #1;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL bp_idle got %b want 0", bus_req); end
    $display("backpressure: fills 0000, 0020, 0060");
    step();
  endtask

  task automatic test_beat_gaps();
    logic [255:0] ew;
    req_vld_w = 1'b1; req_addr_w = 15'h0300;
    #1;
    n_checks++; if (req_rd_w !== 1'b1) begin n_fail++; $display("FAIL gap_req_rd got %b want 1", req_rd_w); end
    step();
    req_vld_w = 1'b0;
    #1;
    n_checks++; if (bus_req_w !== 1'b1) begin n_fail++; $display("FAIL gap_bus_req got %b want 1", bus_req_w); end
    bus_gnt_w = 1'b1;
    step();
    bus_gnt_w = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ew[k*64 +: 64] = {32'hB000_0000 + k, 32'hC000_0000 + k};
      bus_rd_vld_w = 1'b1; bus_rd_data_w = ew[k*64 +: 64];
      #1;
      n_checks++; if (mem_vld_w !== (k == 3)) begin n_fail++; $display("FAIL gap_mem_vld beat %0d got %b want %b", k, mem_vld_w, (k == 3)); end
      if (k == 3) begin
        n_checks++; if (mem_data_w !== ew) begin n_fail++; $display("FAIL gap_data got %h want %h", mem_data_w, ew); end
        n_checks++; if (mem_addr_w !== 15'h0300) begin n_fail++; $display("FAIL gap_mem_addr got %h want 0300", mem_addr_w); end
      end
      step();
      if (k < 3) begin
        bus_rd_vld_w = 1'b0;
        #1;
        n_checks++; if (mem_vld_w !== 1'b0) begin n_fail++; $display("FAIL gap_idle_vld after beat %0d got %b want 0", k, mem_vld_w); end
        step();
      end
    end
    bus_rd_vld_w = 1'b0;
    $display("beat_gaps: 64-bit line 0300");
  endtask

  task automatic test_reset_mid_burst();
    logic to; logic [14:0] ga, ma; int pulses; logic [255:0] md; logic [7:0] rh;
    logic bad;
    req_vld = 1'b1; req_addr = 15'h0500;
    #1;
    n_checks++; if (req_rd !== 1'b1) begin n_fail++; $display("FAIL rmb_req_rd got %b want 1", req_rd); end
    step();
    req_vld = 1'b0;
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_rd_vld = 1'b1; bus_rd_data = 32'h700 + k;
      step();
    end
    rst = 1'b1; bus_rd_data = 32'h704;
    #1;
    n_checks++; if (mem_vld !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL rmb_in_reset got mem_vld=%b bus_req=%b want 0 0", mem_vld, bus_req); end
    step();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_rd_data = 32'h705 + i;
      #1; if (mem_vld || bus_req) bad = 1'b1;
      step();
    end
    bus_rd_vld = 1'b0;
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rmb_stray_beats got activity=%b want 0", bad); end
    req_vld = 1'b1; req_addr = 15'h0600;
    #1;
    n_checks++; if (req_rd !== 1'b1) begin n_fail++; $display("FAIL rmb_new_rd got %b want 1", req_rd); end
    step();
    req_vld = 1'b0;
    burst32(0, 32'h800, to, ga, pulses, ma, md, rh);
    n_checks++; if (to || ga !== 15'h0600 || pulses != 1 || ma !== 15'h0600 || md !== exp32(32'h800)) begin n_fail++; $display("FAIL rmb_refill got pulses=%0d addr=%h want 1 0600", pulses, ma); end
    #1;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rmb_idle got %b want 0", bus_req); end
    $display("reset_mid_burst: refill 0600");
    step();
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_split_pair();
    test_duplicate();
    test_backpressure();
    test_beat_gaps();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
